// File: rtl/structure_tensor_window_pkg.sv
// Shared constants and fixed-point helpers for the structure-tensor window.
package structure_tensor_window_pkg;

    // Ceiling log2; clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        return result;
    endfunction

    // Default-configuration geometry.
    localparam int DATA_W_DEF = 8;
    localparam int WIN_DEF    = 3;
    localparam int WIN_DIM    = WIN_DEF * WIN_DEF;
    localparam int ACC_W      = DATA_W_DEF + clog2(WIN_DIM) + 2;

    // Clamp a signed value into a signed field of the given width.
    function automatic int sat_signed(input int value, input int width);
        int hi;
        int lo;
        int result;
        hi     = (1 << (width - 1)) - 1;
        lo     = -(1 << (width - 1));
        result = value;
        if (value > hi) begin
            result = hi;
        end else if (value < lo) begin
            result = lo;
        end
        return result;
    endfunction

    // Fixed-point product: full signed multiply, floor shift by frac, clamp to width.
    function automatic int fx_mul(input int a, input int b, input int frac, input int width);
        return sat_signed((a * b) >>> frac, width);
    endfunction

endpackage

// File: rtl/structure_tensor_window_adder_tree.sv
// Pipelined pairwise adder tree; one registered level per halving, odd operand passes through.
module tensor_adder_tree
    import structure_tensor_window_pkg::*;
#(
    parameter int DATA_W = 14,
    parameter int N_OPS  = 9
) (
    input  logic                           clk_p,
    input  logic                           rst_n,
    input  logic                           en_p,
    input  logic [N_OPS-1:0][DATA_W-1:0]   operands,
    output logic signed [DATA_W-1:0]       sum
);
    localparam int LEVELS = clog2(N_OPS);
    localparam int LV_N   = (LEVELS > 0) ? LEVELS : 1;

    // lvl_q[l] holds the outputs of tree level l+1.
    logic signed [DATA_W-1:0] lvl_q [LV_N][N_OPS];

    for (genvar gl = 0; gl < LEVELS; gl++) begin : g_level
        localparam int CNT_IN = (N_OPS + (1 << gl) - 1) >> gl;
        logic signed [DATA_W-1:0] src [N_OPS];

        for (genvar gi = 0; gi < N_OPS; gi++) begin : g_src
            if (gl == 0) begin : g_from_ops
                assign src[gi] = operands[gi];
            end else begin : g_from_lvl
                assign src[gi] = lvl_q[gl-1][gi];
            end
        end

        for (genvar gi = 0; gi < N_OPS; gi++) begin : g_node
            if (2 * gi + 1 < CNT_IN) begin : g_add
                // Pairwise add of two operands from the previous level.
                always_ff @(posedge clk_p) begin
                    if (!rst_n) begin
                        lvl_q[gl][gi] <= '0;
                    end else if (en_p) begin
                        lvl_q[gl][gi] <= src[2*gi] + src[2*gi+1];
                    end
                end
            end else if (2 * gi < CNT_IN) begin : g_pass
                // Odd leftover operand moves up unchanged.
                always_ff @(posedge clk_p) begin
                    if (!rst_n) begin
                        lvl_q[gl][gi] <= '0;
                    end else if (en_p) begin
                        lvl_q[gl][gi] <= src[2*gi];
                    end
                end
            end else begin : g_unused
                // Slot beyond this level's width stays at zero.
                always_ff @(posedge clk_p) begin
                    lvl_q[gl][gi] <= '0;
                end
            end
        end
    end

    if (LEVELS > 0) begin : g_sum_reg
        assign sum = lvl_q[LEVELS-1][0];
    end else begin : g_sum_pass
        assign sum = operands[0];
    end

endmodule

// File: rtl/structure_tensor_window.sv
// Streaming structure-tensor window: saturate gradients, slide a WIN x WIN window over
// the raster stream, form Ix*Ix / Ix*Iy / Iy*Iy per tap and sum them through adder trees.
// Optional determinant output (sum_a*sum_c - sum_b^2) is built when TENSOR_DET_EN is defined.
module structure_tensor_window
    import structure_tensor_window_pkg::*;
#(
    parameter int  DATA_W   = 8,
    parameter int  FRAME_W  = 200,
    parameter int  WIN      = 3,
    parameter int  SAT_BITS = 1,
    localparam int N_TAPS   = WIN * WIN,
    localparam int SUM_W    = DATA_W + clog2(WIN * WIN) + 2
) (
    input  logic                     clk_p,
    input  logic                     rst_n,
    input  logic                     en_p,
    input  logic signed [DATA_W-1:0] ix,
    input  logic signed [DATA_W-1:0] iy,
    output logic signed [SUM_W-1:0]  sum_a,
    output logic signed [SUM_W-1:0]  sum_b,
    output logic signed [SUM_W-1:0]  sum_c,
    output logic                     out_valid
`ifdef TENSOR_DET_EN
    ,
    output logic signed [2*SUM_W:0]  det,
    output logic                     det_valid
`endif
);
    localparam int FRAC   = DATA_W - SAT_BITS - 1;
    localparam int LEVELS = clog2(N_TAPS);
    localparam int PIPE_D = LEVELS + 3;   // window + product + tree levels + sum register

    logic signed [DATA_W-1:0]       x_sat, y_sat;
    logic signed [DATA_W-1:0]       tx_q [N_TAPS];
    logic signed [DATA_W-1:0]       ty_q [N_TAPS];
    logic signed [DATA_W-1:0]       pa_q [N_TAPS];
    logic signed [DATA_W-1:0]       pb_q [N_TAPS];
    logic signed [DATA_W-1:0]       pc_q [N_TAPS];
    logic [N_TAPS-1:0][SUM_W-1:0]   op_a, op_b, op_c;
    logic signed [SUM_W-1:0]        tree_a, tree_b, tree_c;
    logic [PIPE_D-1:0]              valid_q;

    assign x_sat = DATA_W'(sat_signed(int'(ix), DATA_W - SAT_BITS));
    assign y_sat = DATA_W'(sat_signed(int'(iy), DATA_W - SAT_BITS));

    // Window row 0 head takes the new sample; other columns shift from their left neighbour.
    for (genvar gi = 0; gi < N_TAPS; gi++) begin : g_tap
        if (gi % WIN != 0) begin : g_shift
            // Column shift within a window row.
            always_ff @(posedge clk_p) begin
                if (!rst_n) begin
                    tx_q[gi] <= '0;
                    ty_q[gi] <= '0;
                end else if (en_p) begin
                    tx_q[gi] <= tx_q[gi-1];
                    ty_q[gi] <= ty_q[gi-1];
                end
            end
        end else if (gi == 0) begin : g_head
            // Newest sample enters tap 0.
            always_ff @(posedge clk_p) begin
                if (!rst_n) begin
                    tx_q[0] <= '0;
                    ty_q[0] <= '0;
                end else if (en_p) begin
                    tx_q[0] <= x_sat;
                    ty_q[0] <= y_sat;
                end
            end
        end
    end

    // Line buffers: row gr head = sample gr*FRAME_W positions older. Buffer 1 is fed from the
    // input (depth FRAME_W); later buffers are fed from the previous row head, which is already
    // one sample late, hence depth FRAME_W-1. The registered read is the row head tap itself.
    for (genvar gr = 1; gr < WIN; gr++) begin : g_line
        localparam int DEPTH = (gr == 1) ? FRAME_W : FRAME_W - 1;
        localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;

        logic [2*DATA_W-1:0] mem [DEPTH];
        logic [2*DATA_W-1:0] wr_data;
        logic [PTR_W-1:0]    ptr_q;
        logic                filled_q;

        if (gr == 1) begin : g_src_in
            assign wr_data = {x_sat, y_sat};
        end else begin : g_src_tap
            assign wr_data = {tx_q[(gr-1)*WIN], ty_q[(gr-1)*WIN]};
        end

        // Storage write; unreset so it maps onto block RAM (stale data is masked by filled_q).
        always_ff @(posedge clk_p) begin
            if (rst_n && en_p) begin
                mem[ptr_q] <= wr_data;
            end
        end

        // Read-before-write into the row head; reads return zero until the buffer has wrapped once.
        always_ff @(posedge clk_p) begin
            if (!rst_n) begin
                ptr_q         <= '0;
                filled_q      <= 1'b0;
                tx_q[gr*WIN]  <= '0;
                ty_q[gr*WIN]  <= '0;
            end else if (en_p) begin
                if (filled_q) begin
                    {tx_q[gr*WIN], ty_q[gr*WIN]} <= mem[ptr_q];
                end else begin
                    tx_q[gr*WIN] <= '0;
                    ty_q[gr*WIN] <= '0;
                end
                if (ptr_q == PTR_W'(DEPTH - 1)) begin
                    ptr_q    <= '0;
                    filled_q <= 1'b1;
                end else begin
                    ptr_q <= ptr_q + PTR_W'(1);
                end
            end
        end
    end

    // Per-tap fixed-point products, sign-extended into the tree width.
    for (genvar gi = 0; gi < N_TAPS; gi++) begin : g_prod
        // Three registered products for this tap.
        always_ff @(posedge clk_p) begin
            if (!rst_n) begin
                pa_q[gi] <= '0;
                pb_q[gi] <= '0;
                pc_q[gi] <= '0;
            end else if (en_p) begin
                pa_q[gi] <= DATA_W'(fx_mul(int'(tx_q[gi]), int'(tx_q[gi]), FRAC, DATA_W));
                pb_q[gi] <= DATA_W'(fx_mul(int'(tx_q[gi]), int'(ty_q[gi]), FRAC, DATA_W));
                pc_q[gi] <= DATA_W'(fx_mul(int'(ty_q[gi]), int'(ty_q[gi]), FRAC, DATA_W));
            end
        end
        assign op_a[gi] = SUM_W'(pa_q[gi]);
        assign op_b[gi] = SUM_W'(pb_q[gi]);
        assign op_c[gi] = SUM_W'(pc_q[gi]);
    end

    tensor_adder_tree #(.DATA_W(SUM_W), .N_OPS(N_TAPS)) u_tree_a (
        .clk_p(clk_p), .rst_n(rst_n), .en_p(en_p), .operands(op_a), .sum(tree_a));
    tensor_adder_tree #(.DATA_W(SUM_W), .N_OPS(N_TAPS)) u_tree_b (
        .clk_p(clk_p), .rst_n(rst_n), .en_p(en_p), .operands(op_b), .sum(tree_b));
    tensor_adder_tree #(.DATA_W(SUM_W), .N_OPS(N_TAPS)) u_tree_c (
        .clk_p(clk_p), .rst_n(rst_n), .en_p(en_p), .operands(op_c), .sum(tree_c));

    // Output sum registers and the valid shift register tracking pipeline fill.
    always_ff @(posedge clk_p) begin
        if (!rst_n) begin
            sum_a   <= '0;
            sum_b   <= '0;
            sum_c   <= '0;
            valid_q <= '0;
        end else if (en_p) begin
            sum_a   <= tree_a;
            sum_b   <= tree_b;
            sum_c   <= tree_c;
            valid_q <= {valid_q[PIPE_D-2:0], en_p};
        end
    end

    assign out_valid = valid_q[PIPE_D-1];

`ifdef TENSOR_DET_EN
    localparam int DET_W = 2 * SUM_W + 1;
    logic signed [DET_W-1:0] det_d;

    // Determinant of the 2x2 tensor from the current sums.
    always_comb begin
        det_d = DET_W'(sum_a) * DET_W'(sum_c) - DET_W'(sum_b) * DET_W'(sum_b);
    end

    // Determinant register, one enabled edge behind the sums.
    always_ff @(posedge clk_p) begin
        if (!rst_n) begin
            det       <= '0;
            det_valid <= 1'b0;
        end else if (en_p) begin
            det       <= det_d;
            det_valid <= out_valid;
        end
    end
`endif

endmodule

// File: tb/tb_structure_tensor_window.sv
// Self-checking bench for structure_tensor_window: random and directed gradient streams
// compared against a window-sum reference computed from the accepted-sample history.
module tb_structure_tensor_window;
    localparam int DATA_W   = 8;
    localparam int FRAME_W  = 200;
    localparam int WIN      = 3;
    localparam int SAT_BITS = 1;
    localparam int ACC_W    = structure_tensor_window_pkg::ACC_W;
    localparam int LAT      = 2 + $clog2(WIN * WIN);
    localparam int FILL     = 620;

    logic                     clk_p = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     en_p  = 1'b0;
    logic signed [DATA_W-1:0] ix    = '0;
    logic signed [DATA_W-1:0] iy    = '0;
    logic signed [ACC_W-1:0]  sum_a, sum_b, sum_c;
    logic                     out_valid;
`ifdef TENSOR_DET_EN
    logic signed [2*ACC_W:0]  det;
    logic                     det_valid;
`endif

    structure_tensor_window #(
        .DATA_W(DATA_W), .FRAME_W(FRAME_W), .WIN(WIN), .SAT_BITS(SAT_BITS)
    ) dut (
        .clk_p(clk_p), .rst_n(rst_n), .en_p(en_p), .ix(ix), .iy(iy),
        .sum_a(sum_a), .sum_b(sum_b), .sum_c(sum_c), .out_valid(out_valid)
`ifdef TENSOR_DET_EN
        , .det(det), .det_valid(det_valid)
`endif
    );

    always #5 clk_p = ~clk_p;

    int checks   = 0;
    int failures = 0;
    int hx[$];
    int hy[$];
    int n_en = 0;
    int ea, eb, ec;
    logic ev;

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int floor_div(input int a, input int d);
        int q;
        q = a / d;
        if ((a % d != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int sat_ref(input int v);
        return clamp(v, -(2 ** (DATA_W - SAT_BITS - 1)), 2 ** (DATA_W - SAT_BITS - 1) - 1);
    endfunction

    function automatic int fmul_ref(input int a, input int b);
        return clamp(floor_div(a * b, 2 ** (DATA_W - SAT_BITS - 1)),
                     -(2 ** (DATA_W - 1)), 2 ** (DATA_W - 1) - 1);
    endfunction

    // Sums shown after enabled edge q: window whose newest sample is index q-1-LAT.
    task automatic sums_at(input int q, output int a, output int b, output int c);
        int p;
        int idx;
        a = 0; b = 0; c = 0;
        p = q - 1 - LAT;
        for (int r = 0; r < WIN; r++) begin
            for (int col = 0; col < WIN; col++) begin
                idx = p - r * FRAME_W - col;
                if (idx >= 0) begin
                    a += fmul_ref(hx[idx], hx[idx]);
                    b += fmul_ref(hx[idx], hy[idx]);
                    c += fmul_ref(hy[idx], hy[idx]);
                end
            end
        end
    endtask

    task automatic expect_now();
        sums_at(n_en, ea, eb, ec);
        ev = (n_en > LAT);
    endtask

    // One clock: drive inputs, take the edge, update the history model, settle.
    task automatic step(input bit en, input int x, input int y);
        en_p = en;
        ix   = DATA_W'(x);
        iy   = DATA_W'(y);
        @(posedge clk_p);
        if (!rst_n) begin
            hx.delete();
            hy.delete();
            n_en = 0;
        end else if (en) begin
            hx.push_back(sat_ref(x));
            hy.push_back(sat_ref(y));
            n_en++;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1'b0, 0, 0);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(1'b1, 5, 5);
        step(1'b1, 5, 5);
        checks++;
        if (sum_a !== '0 || sum_b !== '0 || sum_c !== '0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset: got a=%0d b=%0d c=%0d v=%b, want 0 0 0 0", sum_a, sum_b, sum_c, out_valid);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_constant();
        do_reset();
        for (int i = 0; i < FILL; i++) begin
            step(1'b1, 32, -16);
            expect_now();
            checks++;
            if (sum_a !== ACC_W'(ea) || sum_b !== ACC_W'(eb) || sum_c !== ACC_W'(ec) || out_valid !== ev) begin
                failures++;
                $display("FAIL constant n=%0d: got %0d %0d %0d v=%b, want %0d %0d %0d v=%b",
                         n_en, sum_a, sum_b, sum_c, out_valid, ea, eb, ec, ev);
            end
        end
        checks++;
        if (sum_a !== 14'sd144 || sum_b !== -14'sd72 || sum_c !== 14'sd36 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL constant_steady: got %0d %0d %0d v=%b, want 144 -72 36 v=1", sum_a, sum_b, sum_c, out_valid);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < FILL; i++) begin
            step(1'b1, 100, 0);
            expect_now();
            checks++;
            if (sum_a !== ACC_W'(ea) || sum_b !== ACC_W'(eb) || sum_c !== ACC_W'(ec) || out_valid !== ev) begin
                failures++;
                $display("FAIL saturation n=%0d: got %0d %0d %0d v=%b, want %0d %0d %0d v=%b",
                         n_en, sum_a, sum_b, sum_c, out_valid, ea, eb, ec, ev);
            end
        end
        checks++;
        if (sum_a !== 14'sd558 || sum_b !== '0 || sum_c !== '0) begin
            failures++;
            $display("FAIL saturation_steady: got %0d %0d %0d, want 558 0 0", sum_a, sum_b, sum_c);
        end
    endtask

    task automatic test_rounding();
        do_reset();
        for (int i = 0; i < FILL; i++) begin
            step(1'b1, 1, -1);
            expect_now();
            checks++;
            if (sum_a !== ACC_W'(ea) || sum_b !== ACC_W'(eb) || sum_c !== ACC_W'(ec) || out_valid !== ev) begin
                failures++;
                $display("FAIL rounding n=%0d: got %0d %0d %0d v=%b, want %0d %0d %0d v=%b",
                         n_en, sum_a, sum_b, sum_c, out_valid, ea, eb, ec, ev);
            end
        end
        checks++;
        if (sum_a !== '0 || sum_b !== -14'sd9 || sum_c !== '0) begin
            failures++;
            $display("FAIL rounding_steady: got %0d %0d %0d, want 0 -9 0", sum_a, sum_b, sum_c);
        end
    endtask

    task automatic test_latency();
        int want;
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 0, 0);
        step(1'b1, 32, 0);
        for (int k = 1; k <= LAT + WIN; k++) begin
            step(1'b1, 0, 0);
            want = (k >= LAT && k < LAT + WIN) ? 16 : 0;
            checks++;
            if (sum_a !== ACC_W'(want)) begin
                failures++;
                $display("FAIL latency k=%0d: got sum_a=%0d, want %0d", k, sum_a, want);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        for (int it = 0; it < 4 * FILL && n_en < FILL; it++) begin
            step(1'($urandom_range(0, 1)), 32, -16);
            expect_now();
            checks++;
            if (sum_a !== ACC_W'(ea) || sum_b !== ACC_W'(eb) || sum_c !== ACC_W'(ec) || out_valid !== ev) begin
                failures++;
                $display("FAIL stall it=%0d n=%0d en=%b: got %0d %0d %0d v=%b, want %0d %0d %0d v=%b",
                         it, n_en, en_p, sum_a, sum_b, sum_c, out_valid, ea, eb, ec, ev);
            end
        end
        checks++;
        if (sum_a !== 14'sd144 || sum_b !== -14'sd72 || sum_c !== 14'sd36 || n_en < FILL) begin
            failures++;
            $display("FAIL stall_steady: got %0d %0d %0d after %0d enabled, want 144 -72 36 after %0d",
                     sum_a, sum_b, sum_c, n_en, FILL);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 300; i++) step(1'b1, 32, -16);
        rst_n = 1'b0;
        step(1'b1, 32, -16);
        rst_n = 1'b1;
        checks++;
        if (sum_a !== '0 || sum_b !== '0 || sum_c !== '0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_clear: got %0d %0d %0d v=%b, want 0 0 0 0", sum_a, sum_b, sum_c, out_valid);
        end
        for (int i = 0; i < FILL; i++) begin
            step(1'b1, 32, -16);
            expect_now();
            checks++;
            if (sum_a !== ACC_W'(ea) || sum_b !== ACC_W'(eb) || sum_c !== ACC_W'(ec) || out_valid !== ev) begin
                failures++;
                $display("FAIL reset_mid n=%0d: got %0d %0d %0d v=%b, want %0d %0d %0d v=%b",
                         n_en, sum_a, sum_b, sum_c, out_valid, ea, eb, ec, ev);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int it = 0; it < 1200; it++) begin
            step(($urandom_range(0, 3) != 0), int'($urandom_range(0, 255)) - 128,
                 int'($urandom_range(0, 255)) - 128);
            expect_now();
            checks++;
            if (sum_a !== ACC_W'(ea) || sum_b !== ACC_W'(eb) || sum_c !== ACC_W'(ec) || out_valid !== ev) begin
                failures++;
                $display("FAIL random it=%0d n=%0d: got %0d %0d %0d v=%b, want %0d %0d %0d v=%b",
                         it, n_en, sum_a, sum_b, sum_c, out_valid, ea, eb, ec, ev);
            end
        end
    endtask

`ifdef TENSOR_DET_EN
    task automatic test_det();
        longint dv;
        logic   dvalid;
        do_reset();
        for (int i = 0; i < FILL; i++) begin
            step(1'b1, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
            sums_at(n_en - 1, ea, eb, ec);
            dv     = longint'(ea) * longint'(ec) - longint'(eb) * longint'(eb);
            dvalid = (n_en > LAT + 1);
            checks++;
            if (det !== (2*ACC_W+1)'(dv) || det_valid !== dvalid) begin
                failures++;
                $display("FAIL det n=%0d: got %0d v=%b, want %0d v=%b", n_en, det, det_valid, dv, dvalid);
            end
        end
        do_reset();
        for (int i = 0; i < FILL; i++) step(1'b1, 32, -16);
        checks++;
        if (det !== '0 || det_valid !== 1'b1) begin
            failures++;
            $display("FAIL det_constant: got %0d v=%b, want 0 v=1", det, det_valid);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_constant();
        test_saturation();
        test_rounding();
        test_latency();
        test_stall();
        test_reset_mid();
        test_random();
`ifdef TENSOR_DET_EN
        test_det();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
